// File: rtl/usi_pkg.sv
// Shared definitions for the USI transmitter/receiver pair: FSM encoding,
// pattern RAM size and bit-index/period widths.
package usi_pkg;

  localparam int USI_MEM_AW = 14;
  localparam int IDX_W      = 17;
  localparam int DIV_W      = 18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/usi_bitmem.sv
// Simple dual-port byte RAM: host port writes/reads, engine port reads only.
// Both read ports are registered (1-cycle latency); contents are never reset.
module usi_bitmem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  input  logic [AW-1:0] eng_addr,
  output logic [7:0]    eng_rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    host_rdata <= mem[host_addr];
    eng_rdata  <= mem[eng_addr];
  end

endmodule

// File: rtl/usitx.sv
// USI transmitter: replays a host-programmed bit pattern from RAM on dataout,
// one bit per clkdivider+1 clocks, LSB of byte 0 first, then reports done.
module usitx
  import usi_pkg::*;
#(
  parameter int MEM_AW = USI_MEM_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idle,
  output logic        dataout,
  input  logic        run,
  output logic        done,
  output logic        busy,
  input  logic [16:0] num_states,
  input  logic [17:0] clkdivider,
  input  logic        state_prog_en,
  input  logic [15:0] state_prog_addr,
  input  logic        state_prog_wr,
  input  logic [7:0]  state_prog_data,
  output logic [7:0]  state_prog_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a rising edge of run in IDLE starts a transfer; busy stays high
  // until done or abort; done stays high until run is dropped; run low while
  // busy aborts and a fresh rising edge is needed for the next transfer.

  logic [1:0]        state;
  logic              run_q;
  logic [IDX_W-1:0]  ns_q;
  logic [IDX_W-1:0]  idx;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic [7:0]        byte_q;
  logic [7:0]        eng_rdata;
  logic [7:0]        cur_byte;
  logic [MEM_AW-1:0] eng_addr;
  logic              host_we;
  logic              first_cyc;
  logic              last_cyc;
  logic              cur_bit;
  logic              unused_addr_hi;

  assign dbg_state      = state;
  assign host_we        = state_prog_en & state_prog_wr & ~busy;
  assign unused_addr_hi = ^state_prog_addr[15:MEM_AW];

  // The engine port always points one byte ahead while shifting, so the next
  // byte is already registered when the current byte's bit 7 finishes.
  assign eng_addr  = (state == ST_SHIFT) ? (MEM_AW'(idx[IDX_W-1:3]) + MEM_AW'(1)) : '0;
  assign first_cyc = (idx[2:0] == 3'd0) && (cnt == '0);
  assign cur_byte  = first_cyc ? eng_rdata : byte_q;
  assign cur_bit   = cur_byte[idx[2:0]];
  assign last_cyc  = (cnt == div_q);

  usi_bitmem #(.AW(MEM_AW)) u_mem (
    .clk        (clk),
    .host_we    (host_we),
    .host_addr  (state_prog_addr[MEM_AW-1:0]),
    .host_wdata (state_prog_data),
    .host_rdata (state_prog_rdata),
    .eng_addr   (eng_addr),
    .eng_rdata  (eng_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      run_q   <= 1'b0;
      dataout <= idle;
      done    <= 1'b0;
      busy    <= 1'b0;
      ns_q    <= '0;
      div_q   <= '0;
      idx     <= '0;
      cnt     <= '0;
      byte_q  <= '0;
    end else begin
      run_q <= run;
      case (state)
        ST_IDLE: begin
          dataout <= idle;
          done    <= 1'b0;
          busy    <= 1'b0;
          if (run && !run_q) begin
            ns_q  <= num_states;
            div_q <= clkdivider;
            idx   <= '0;
            cnt   <= '0;
            if (num_states == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (!run) begin
            state   <= ST_IDLE;
            dataout <= idle;
            busy    <= 1'b0;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!run) begin
            state   <= ST_IDLE;
            dataout <= idle;
            busy    <= 1'b0;
          end else begin
            dataout <= cur_bit;
            if (first_cyc) byte_q <= eng_rdata;
            if (last_cyc) begin
              cnt <= '0;
              if (idx == ns_q - 1'b1) state <= ST_DONE;
              else                    idx   <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          dataout <= idle;
          done    <= 1'b1;
          busy    <= 1'b0;
          if (!run) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usitx.sv
// Bench for usitx: directed scenarios plus randomized transfers, checked by a
// per-cycle scoreboard fed from a bit-level reference model of the pattern.
module tb_usitx;

  logic        clk = 1'b0;
  logic        rst;
  logic        idle;
  logic        dataout;
  logic        run;
  logic        done;
  logic        busy;
  logic [16:0] num_states;
  logic [17:0] clkdivider;
  logic        state_prog_en;
  logic [15:0] state_prog_addr;
  logic        state_prog_wr;
  logic [7:0]  state_prog_data;
  logic [7:0]  state_prog_rdata;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int item_no = 0;
  string cur_name = "none";

  // Each entry is {dataout, done, busy} expected after one clock edge.
  logic [2:0] exp_q[$];
  logic [7:0] model_mem [0:15];

  always #5 clk = ~clk;

  usitx dut (
    .clk              (clk),
    .rst              (rst),
    .idle             (idle),
    .dataout          (dataout),
    .run              (run),
    .done             (done),
    .busy             (busy),
    .num_states       (num_states),
    .clkdivider       (clkdivider),
    .state_prog_en    (state_prog_en),
    .state_prog_addr  (state_prog_addr),
    .state_prog_wr    (state_prog_wr),
    .state_prog_data  (state_prog_data),
    .state_prog_rdata (state_prog_rdata),
    .dbg_state        (dbg_state)
  );

  // Monitor: one scoreboard entry per clock edge while a transfer is tracked.
  always @(posedge clk) begin
    logic [2:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({dataout, done, busy} !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got dataout/done/busy=%b expected %b",
                 cur_name, item_no, {dataout, done, busy}, e);
      end
      item_no++;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_bit(input int k);
    logic [7:0] b;
    b = model_mem[k / 8];
    return b[k % 8];
  endfunction

  task automatic host_write(input int a, input logic [7:0] d, input bit honoured);
    logic [15:0] addr;
    addr = 16'(a) | 16'($urandom_range(0, 3) << 14);
    @(negedge clk);
    state_prog_en   = 1'b1;
    state_prog_wr   = 1'b1;
    state_prog_addr = addr;
    state_prog_data = d;
    @(negedge clk);
    state_prog_en = 1'b0;
    state_prog_wr = 1'b0;
    if (honoured) model_mem[a] = d;
  endtask

  task automatic host_read_check(input string name, input int a);
    @(negedge clk);
    state_prog_en   = 1'b1;
    state_prog_addr = 16'(a) | 16'($urandom_range(0, 3) << 14);
    @(posedge clk);
    #2;
    check(name, state_prog_rdata, model_mem[a]);
    @(negedge clk);
    state_prog_en = 1'b0;
  endtask

  // Expected line behaviour after the run edge (j = edges since the run edge):
  // two cycles of latency, then ns bits of div+1 clocks each, then done/idle.
  task automatic push_expect(input int ns, input int div, input logic iv, input int cut);
    int p;
    int total;
    int len;
    p     = div + 1;
    total = 2 + ns * p;
    len   = (cut >= 0) ? cut + 3 : total + 4;
    for (int j = 0; j < len; j++) begin
      logic [2:0] e;
      if (cut >= 0 && j >= cut)  e = {iv, 1'b0, 1'b0};
      else if (ns == 0)          e = {iv, (j >= 1), 1'b0};
      else if (j < 2)            e = {iv, 1'b0, 1'b1};
      else if (j < total)        e = {model_bit((j - 2) / p), 1'b0, 1'b1};
      else                       e = {iv, 1'b1, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic run_txn(input string name, input int ns, input int div, input logic iv,
                         input int cut, input bit use_rst);
    int k;
    @(negedge clk);
    idle = iv;
    run  = 1'b0;
    repeat (3) @(negedge clk);
    cur_name   = name;
    item_no    = 0;
    num_states = 17'(ns);
    clkdivider = 18'(div);
    run        = 1'b1;
    push_expect(ns, div, iv, cut);
    if (cut >= 0) begin
      repeat (cut) @(negedge clk);
      run = 1'b0;
      if (use_rst) rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s drain: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_done_low"}, {7'd0, done}, 8'd0);
    check({name, "_busy_low"}, {7'd0, busy}, 8'd0);
    check({name, "_line_idle"}, {7'd0, dataout}, {7'd0, iv});
  endtask

  initial begin
    rst             = 1'b0;
    idle            = 1'b1;
    run             = 1'b0;
    num_states      = '0;
    clkdivider      = '0;
    state_prog_en   = 1'b0;
    state_prog_wr   = 1'b0;
    state_prog_addr = '0;
    state_prog_data = '0;

    repeat (2) @(posedge clk);
    #2;
    check("reset_dataout", {7'd0, dataout}, 8'd1);
    check("reset_done", {7'd0, done}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 16; a++) host_write(a, 8'($urandom_range(0, 255)), 1'b1);

    // Back-to-back single-clock bits across byte boundaries.
    host_write(0, 8'hAA, 1'b1);
    host_write(1, 8'h55, 1'b1);
    host_write(2, 8'hFF, 1'b1);
    run_txn("div0_24", 24, 0, 1'b0, -1, 1'b0);

    run_txn("zero_states", 0, 5, 1'b1, -1, 1'b0);

    host_write(0, 8'h05, 1'b1);
    host_write(1, 8'h01, 1'b1);
    run_txn("basic_10x9", 10, 8, 1'b1, -1, 1'b0);

    // Abort with run dropped while bit 20 would begin.
    run_txn("abort_bit20", 100, 3, 1'b1, 2 + 20 * 4, 1'b0);

    run_txn("reset_mid", 40, 2, 1'b0, 2 + 5 * 3, 1'b1);
    host_read_check("ram_after_reset", 0);

    fork
      run_txn("busy_write", 40, 2, 1'b1, -1, 1'b0);
      begin
        repeat (12) @(negedge clk);
        host_write(0, 8'hFF, 1'b0);
      end
    join
    host_read_check("ram_after_busy_wr", 0);

    for (int t = 0; t < 14; t++) begin
      int ns;
      int div;
      repeat (3) host_write($urandom_range(0, 15), 8'($urandom_range(0, 255)), 1'b1);
      ns  = (t == 0) ? 128 : (t == 1) ? 1 : $urandom_range(0, 128);
      div = $urandom_range(0, 5);
      run_txn($sformatf("rand%0d", t), ns, div, 1'($urandom_range(0, 1)), -1, 1'b0);
      host_read_check($sformatf("rand_rd%0d", t), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
